// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the dmem arbiter.
// MMIO map is shared with the dmem/peripheral block.
package dmem_arb_pkg;

  typedef enum logic {
    CPU_OWN = 1'b0,
    DMA_OWN = 1'b1
  } arb_state_t;

  localparam logic [1:0] PERIPH_TAG = 2'b11;

  localparam logic [31:0] MMIO_SWITCHES = 32'hC000_0000;
  localparam logic [31:0] MMIO_LEDS     = 32'hC000_0004;
  localparam logic [31:0] MMIO_DISP_NUM = 32'hC000_0008;
  localparam logic [31:0] MMIO_DISP_LET = 32'hC000_000C;
  localparam logic [31:0] MMIO_ENTER    = 32'hC000_0010;

  function automatic logic is_periph(input logic [31:0] a);
    return a[31:30] == PERIPH_TAG;
  endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// arb_starve_ctr: counts consecutive denied DMA cycles and
// raises force_dma once the DMA master has waited long enough.
module arb_starve_ctr
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dma_req,
  input  logic       dma_bad,
  input  logic       sel_dma,
  input  logic       own_exit,
  input  arb_state_t st,
  output logic [3:0] wait_cnt,
  output logic       force_dma
);

  localparam logic [3:0] WMAX = 4'(MAX_WAIT);

  logic [3:0] wait_cnt_d;
  logic [3:0] wait_cnt_q;

  // Clear on grant, on idle DMA or when leaving a burst; else saturate up.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (sel_dma || !dma_req || own_exit) begin
      wait_cnt_d = 4'd0;
    end else if (!dma_bad && (wait_cnt_q != WMAX)) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  // Wait counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= 4'd0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign wait_cnt  = wait_cnt_q;
  assign force_dma = (st == DMA_OWN) || (wait_cnt_q == WMAX);

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the dmem port between the CPU (priority)
// and a DMA/loader master with starvation and burst bounds.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT  = 4,
  parameter int unsigned BURST_LEN = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_a,
  input  logic [31:0] cpu_wd,
  output logic [31:0] cpu_rd,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_a,
  input  logic [31:0] dma_wd,
  output logic [31:0] dma_rd,
  output logic        dma_gnt,
  output logic        dma_err,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam logic [3:0] WMAX = 4'(MAX_WAIT);
  localparam logic [4:0] BLEN = 5'(BURST_LEN);

  arb_state_t st_d;
  arb_state_t st_q;
  logic [3:0] burst_cnt_d;
  logic [3:0] burst_cnt_q;
  logic       dma_err_d;
  logic       dma_err_q;

  logic       dma_bad;
  logic       sel_dma;
  logic       force_dma;
  logic       own_exit;
  logic [3:0] wait_cnt;
  logic [4:0] burst_inc;

  assign dma_bad = dma_req && is_periph(dma_a);
  assign sel_dma = !reset && dma_req && !dma_bad &&
                   (!cpu_req || force_dma);

  assign dma_gnt   = sel_dma;
  assign cpu_stall = cpu_req && sel_dma;

  assign mem_a  = sel_dma ? dma_a  : cpu_a;
  assign mem_wd = sel_dma ? dma_wd : cpu_wd;
  assign mem_we = !reset &&
                  (sel_dma ? dma_we : (cpu_we && cpu_req));

  assign cpu_rd = mem_rd;
  assign dma_rd = mem_rd;

  arb_starve_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .clk       (clk),
    .reset     (reset),
    .dma_req   (dma_req),
    .dma_bad   (dma_bad),
    .sel_dma   (sel_dma),
    .own_exit  (own_exit),
    .st        (st_q),
    .wait_cnt  (wait_cnt),
    .force_dma (force_dma)
  );

  assign burst_inc = {1'b0, burst_cnt_q} + 5'd1;

  // Ownership FSM; burst_cnt counts grants already made in the burst,
  // the entry grant included, so a burst is exactly BURST_LEN grants.
  always_comb begin
    st_d        = st_q;
    burst_cnt_d = burst_cnt_q;
    own_exit    = 1'b0;
    unique case (st_q)
      CPU_OWN: begin
        if (sel_dma && cpu_req && (wait_cnt == WMAX)) begin
          st_d        = DMA_OWN;
          burst_cnt_d = 4'd1;
        end
      end
      DMA_OWN: begin
        if (!dma_req || dma_bad) begin
          own_exit = 1'b1;
        end else if (sel_dma) begin
          if (burst_inc >= BLEN) begin
            own_exit = 1'b1;
          end else begin
            burst_cnt_d = burst_inc[3:0];
          end
        end
      end
      default: own_exit = 1'b1;
    endcase
    if (own_exit) begin
      st_d        = CPU_OWN;
      burst_cnt_d = 4'd0;
    end
  end

  // Rejected peripheral requests report one cycle later.
  always_comb begin
    dma_err_d = dma_bad;
  end

  // State, burst counter and error pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q        <= CPU_OWN;
      burst_cnt_q <= 4'd0;
      dma_err_q   <= 1'b0;
    end else begin
      st_q        <= st_d;
      burst_cnt_q <= burst_cnt_d;
      dma_err_q   <= dma_err_d;
    end
  end

  assign dma_err = dma_err_q;

endmodule
